iterative_multiply_unit: RTL

Multi-cycle execute pipe on the receiving end of the decode-issue D→X interface: accepts `MUL` micro-ops from the decode-issue unit, computes the low 32 bits of the product with a one-bit-per-cycle shift-add datapath, and hands the result plus renaming metadata to writeback over the X→W interface. It is one entry in the decode-issue unit's pipe array, so its pipe subset lists only `MUL`.

---
 rtl/iterative_multiply_unit_pkg.sv | 12 +
 rtl/D__XIntf.sv | 25 ++
 rtl/X__WIntf.sv | 23 ++
 rtl/iterative_multiply_unit_mul_shift_add_step.sv | 16 +
 rtl/iterative_multiply_unit.sv | 100 ++++++++++
 5 files changed

// File: rtl/iterative_multiply_unit_pkg.sv
// Shared types and widths for the iterative multiply pipe and its D->X / X->W interfaces.
// The uop encoding mirrors the ISA micro-op list used by decode-issue.
package iterative_multiply_unit_pkg;
   localparam int XLEN       = 32;
   localparam int PC_W       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [3:0] {
      UOP_ADD, UOP_SUB, UOP_AND, UOP_OR, UOP_XOR, UOP_SLL, UOP_SRL,
      UOP_MUL, UOP_LW, UOP_SW, UOP_BNE
   } uop_t;
endpackage

// File: rtl/D__XIntf.sv
// Decode-issue to execute-pipe handshake: one micro-op with operands and renaming metadata.
interface D__XIntf #(
   parameter int p_seq_num_bits  = 8,
   parameter int p_num_phys_regs = 36
);
   import iterative_multiply_unit_pkg::*;
   localparam int PREG_W = $clog2(p_num_phys_regs);

   logic                      val;
   logic                      rdy;
   logic [PC_W-1:0]           pc;
   logic [XLEN-1:0]           op1;
   logic [XLEN-1:0]           op2;
   logic [XLEN-1:0]           mem_data;
   uop_t                      uop;
   logic [REG_ADDR_W-1:0]     waddr;
   logic [p_seq_num_bits-1:0] seq_num;
   logic [PREG_W-1:0]         preg;
   logic [PREG_W-1:0]         ppreg;

   modport D_intf (output val, pc, op1, op2, mem_data, uop, waddr, seq_num, preg, ppreg,
                   input rdy);
   modport X_intf (input val, pc, op1, op2, mem_data, uop, waddr, seq_num, preg, ppreg,
                   output rdy);
endinterface

// File: rtl/X__WIntf.sv
// Execute-pipe to writeback handshake: result, write enable and renaming metadata.
interface X__WIntf #(
   parameter int p_seq_num_bits  = 8,
   parameter int p_num_phys_regs = 36
);
   import iterative_multiply_unit_pkg::*;
   localparam int PREG_W = $clog2(p_num_phys_regs);

   logic                      val;
   logic                      rdy;
   logic [PC_W-1:0]           pc;
   logic [p_seq_num_bits-1:0] seq_num;
   logic [REG_ADDR_W-1:0]     waddr;
   logic [XLEN-1:0]           wdata;
   logic                      wen;
   logic [PREG_W-1:0]         preg;
   logic [PREG_W-1:0]         ppreg;

   modport X_intf (output val, pc, seq_num, waddr, wdata, wen, preg, ppreg,
                   input rdy);
   modport W_intf (input val, pc, seq_num, waddr, wdata, wen, preg, ppreg,
                   output rdy);
endinterface

// File: rtl/iterative_multiply_unit_mul_shift_add_step.sv
// One shift-add multiply step: conditionally add the multiplicand, then shift both operands.
module iterative_multiply_unit_mul_shift_add_step
   import iterative_multiply_unit_pkg::*;
(
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] acc_nxt,
   output logic [XLEN-1:0] a_nxt,
   output logic [XLEN-1:0] b_nxt
);
   // Carry out of the add is dropped: only the low XLEN bits of the product are kept.
   assign acc_nxt = b[0] ? (acc + a) : acc;
   assign a_nxt   = {a[XLEN-2:0], 1'b0};
   assign b_nxt   = {1'b0, b[XLEN-1:1]};
endmodule

// File: rtl/iterative_multiply_unit.sv
// MUL execute pipe: 32-cycle shift-add multiplier between the D->X and X->W handshakes.
module iterative_multiply_unit
   import iterative_multiply_unit_pkg::*;
#(
   parameter int p_num_phys_regs = 36
)(
   input logic     clk,
   input logic     rst,
   D__XIntf.X_intf D,
   X__WIntf.X_intf W
);
   localparam int p_seq_num_bits = D.p_seq_num_bits;
   localparam int PREG_W         = $clog2(p_num_phys_regs);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam logic [4:0] LAST_STEP = 5'd31;

   state_t                    state, state_nxt;
   logic [4:0]                count;
   logic [XLEN-1:0]           acc, a, b;
   logic [XLEN-1:0]           acc_step, a_step, b_step;
   logic [PC_W-1:0]           pc_q;
   logic [p_seq_num_bits-1:0] seq_q;
   logic [REG_ADDR_W-1:0]     waddr_q;
   logic [PREG_W-1:0]         preg_q, ppreg_q;
   logic                      d_fire;

   assign d_fire = D.val && (state == IDLE);

   iterative_multiply_unit_mul_shift_add_step u_step (
      .acc     (acc),
      .a       (a),
      .b       (b),
      .acc_nxt (acc_step),
      .a_nxt   (a_step),
      .b_nxt   (b_step)
   );

   // Handshake outputs decode from state only, so D.rdy never depends on D.val.
   always_comb begin
      state_nxt = state;
      D.rdy     = 1'b0;
      W.val     = 1'b0;
      case (state)
         IDLE: begin
            D.rdy = 1'b1;
            if (D.val) state_nxt = CALC;
         end
         CALC: begin
            if (count == LAST_STEP) state_nxt = DONE;
         end
         DONE: begin
            W.val = 1'b1;
            if (W.rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         if (d_fire) begin
            acc   <= '0;
            count <= '0;
         end else if (state == CALC) begin
            acc   <= acc_step;
            count <= count + 5'd1;
         end
      end
   end

   // Operands and metadata carry no reset; they are only meaningful after an accept.
   always_ff @(posedge clk) begin
      if (d_fire) begin
         a       <= D.op1;
         b       <= D.op2;
         pc_q    <= D.pc;
         seq_q   <= D.seq_num;
         waddr_q <= D.waddr;
         preg_q  <= D.preg;
         ppreg_q <= D.ppreg;
      end else if (state == CALC) begin
         a <= a_step;
         b <= b_step;
      end
   end

   assign W.wdata   = acc;
   assign W.wen     = (waddr_q != '0);
   assign W.pc      = pc_q;
   assign W.seq_num = seq_q;
   assign W.waddr   = waddr_q;
   assign W.preg    = preg_q;
   assign W.ppreg   = ppreg_q;
endmodule
